// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART transmit constants, state encoding and frame helper.
package uart_tx_fifo_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Bit periods in one complete frame: start + data + stop.
  function automatic int frame_bits();
    return 1 + DATA_BITS + STOP_BITS;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte stream handshake from the accelerator output stage into the UART transmitter.
interface uart_tx_fifo_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo_sync_byte_fifo.sv
// Single-clock byte FIFO with occupancy count; shared by the UART TX and RX paths.
module uart_tx_fifo_sync_byte_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [7:0]                  push_data,
  input  logic                        pop,
  output logic [7:0]                  pop_data,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        empty,
  output logic                        full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Guarded locally so a careless caller cannot corrupt the pointers.
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter, LSB first, returning accelerator result bytes to the host.
//
// state    | meaning
// ST_IDLE  | line high, waiting for a buffered byte
// ST_START | start bit (line low) for one bit period
// ST_DATA  | eight data bits from shift[0], LSB first
// ST_STOP  | stop bit (line high); chains straight into the next frame if data is waiting
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_tx_fifo_if.slave               in_bus,
  output logic                        tx_out,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  import uart_tx_fifo_pkg::*;

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_end;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;
  logic [7:0]        pop_data;

  assign push         = in_bus.valid && in_bus.ready;
  assign in_bus.ready = !full;
  assign bit_end      = (baud_q == BAUD_LAST);
  assign tx_out       = tx_q;
  assign tx_busy      = (state_q != ST_IDLE);

  uart_tx_fifo_sync_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_bus.data),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (fifo_count),
    .empty     (empty),
    .full      (full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = pop_data;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = pop_data;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is registered from the next state so tx_out never glitches.
    tx_d = (state_d == ST_DATA) ? shift_d[0] : (state_d != ST_START);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: accepted bytes are queued, a host-side UART receiver decodes tx_out and compares.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int CPB   = 10;
  localparam int DEPTH = 8;
  localparam int FRAME = CPB * frame_bits();

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_out;
  logic       tx_busy;
  logic [3:0] fifo_count;

  uart_tx_fifo_if bus();

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_bus     (bus),
    .tx_out     (tx_out),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         bad = 0;
  int         inv_bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] d, output int edge_n);
    logic acc;
    int   g;
    g = 0;
    bus.valid = 1'b1;
    bus.data  = d;
    do begin
      acc = bus.ready;
      @(posedge clk);
      #1;
      g++;
    end while (!acc && g < 5000);
    bus.valid = 1'b0;
    edge_n = cyc;
    if (acc) exp_q.push_back(d);
    else begin
      total++;
      bad++;
      $display("FAIL push_timeout: byte %0d never accepted", d);
    end
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while ((tx_busy !== 1'b0 || fifo_count !== 4'd0) && g < 5000) begin
      step();
      g++;
    end
    check({name, "_drained"}, 32'(g < 5000), 1);
    repeat (3) step();
    check({name, "_all_received"}, exp_q.size(), 0);
  endtask

  // Rules that hold on every cycle outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ready !== (fifo_count < DEPTH)) inv_bad++;
      if (fifo_count > DEPTH) inv_bad++;
    end
  end

  // Host receiver: sample each bit at its midpoint; frames cut by reset are dropped.
  initial begin : monitor
    logic [7:0] rx;
    logic       abort;
    forever begin
      @(negedge clk);
      if (!reset && tx_out === 1'b0) begin
        abort = 1'b0;
        rx    = '0;
        repeat (CPB/2) begin @(negedge clk); if (reset) abort = 1'b1; end
        if (!abort) check("rx_start_bit", 32'(tx_out), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(negedge clk); if (reset) abort = 1'b1; end
          rx[i] = tx_out;
        end
        repeat (CPB) begin @(negedge clk); if (reset) abort = 1'b1; end
        if (!abort) begin
          check("rx_stop_bit", 32'(tx_out), 1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected: got byte %0d want no frame", rx);
          end else begin
            check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k, k1, tmp, accepted, next, first_edge, max_cnt, guard, lows, busy_hits;
    logic acc, rise_seen;

    bus.valid = 1'b0;
    bus.data  = '0;
    reset     = 1'b1;
    repeat (3) step();
    check("reset_tx_out", 32'(tx_out), 1);
    check("reset_tx_busy", 32'(tx_busy), 0);
    check("reset_in_ready", 32'(bus.ready), 1);
    check("reset_fifo_count", 32'(fifo_count), 0);
    reset = 1'b0;
    repeat (3) step();
    check("idle_tx_out", 32'(tx_out), 1);

    // Single byte: latency and frame length
    push_one(8'h0A, k);
    check("t1_line_high_at_k", 32'(tx_out), 1);
    step();
    check("t1_start_at_k1", 32'(tx_out), 0);
    guard = 0;
    while (tx_busy === 1'b1 && guard < 1000) begin step(); guard++; end
    check("t1_busy_cycles", cyc - (k + 1), FRAME);
    wait_idle("t1");

    // Back-to-back frames must be contiguous
    push_one(8'h01, k);
    push_one(8'h80, tmp);
    push_one(8'hFF, tmp);
    guard = 0;
    while (tx_busy === 1'b1 && guard < 1000) begin step(); guard++; end
    check("t2_busy_cycles", cyc - (k + 1), 3 * FRAME);
    wait_idle("t2");

    // Backpressure and pointer wrap: 20 incrementing bytes with valid held high
    accepted = 0; next = 0; first_edge = 0; max_cnt = 0; guard = 0; rise_seen = 1'b0;
    bus.valid = 1'b1;
    while (accepted < 20 && guard < 5000) begin
      bus.data = 8'(next);
      acc = bus.ready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        exp_q.push_back(8'(next));
        if (accepted == 0) first_edge = cyc;
        accepted++;
        next++;
        if (accepted == 9) begin
          check("t3_count_full", 32'(fifo_count), DEPTH);
          check("t3_ready_low", 32'(bus.ready), 0);
        end
      end
      if (accepted >= 9 && !rise_seen && bus.ready === 1'b1) begin
        rise_seen = 1'b1;
        check("t3_ready_rise_edge", cyc, first_edge + 1 + FRAME);
      end
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
    bus.valid = 1'b0;
    check("t4_accepted", accepted, 20);
    check("t4_max_count", max_cnt, DEPTH);
    wait_idle("t4");
    check("t4_end_count", 32'(fifo_count), 0);
    check("t4_end_tx_out", 32'(tx_out), 1);

    // Asynchronous reset during data bit 3 of 0xA5 with four bytes queued
    push_one(8'hA5, k);
    for (int i = 0; i < 4; i++) push_one(8'($urandom), tmp);
    while (cyc < k + 1 + 4 * CPB + CPB/2) step();
    check("t5_bit3_level", 32'(tx_out), 0);
    check("t5_count_before", 32'(fifo_count), 4);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("t5_async_tx_out", 32'(tx_out), 1);
    check("t5_async_tx_busy", 32'(tx_busy), 0);
    check("t5_async_count", 32'(fifo_count), 0);
    repeat (3) step();
    #2;
    reset = 1'b0;
    lows = 0; busy_hits = 0;
    repeat (200) begin
      step();
      if (tx_out !== 1'b1) lows++;
      if (tx_busy !== 1'b0) busy_hits++;
    end
    check("t5_quiet_tx_low_cycles", lows, 0);
    check("t5_quiet_busy_cycles", busy_hits, 0);

    // Push lands exactly on the stop-to-start edge while one byte waits
    push_one(8'h3C, k);
    push_one(8'hC3, k1);
    check("t6_count_one", 32'(fifo_count), 1);
    while (cyc < k + FRAME) step();
    check("t6_count_before_edge", 32'(fifo_count), 1);
    bus.valid = 1'b1;
    bus.data  = 8'h5A;
    acc = bus.ready;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    if (acc) exp_q.push_back(8'h5A);
    check("t6_accepted", 32'(acc), 1);
    check("t6_edge", cyc, k + 1 + FRAME);
    check("t6_count_after", 32'(fifo_count), 1);
    check("t6_next_start", 32'(tx_out), 0);
    wait_idle("t6");

    // Random bytes with random gaps
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) step();
      push_one(8'($urandom), tmp);
    end
    wait_idle("t7");
    check("ready_count_rules", inv_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
